// File: rtl/ixu_pkg.sv
// Shared types and defaults for the IXU execute pipe.
package ixu_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int SEXT_W         = 64;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } ixu_op_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } ixu_ex_state_e;

    // Wide enough for any supported XLEN; callers truncate.
    function automatic logic [SEXT_W-1:0] sext12(input logic [11:0] imm);
        return {{(SEXT_W-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/ixu_mul_iter.sv
// Iterative shift-add multiplier, XLEN/MUL_CYCLES multiplier bits per cycle.
module ixu_mul_iter
    import ixu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            hold,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last,
    output logic [XLEN-1:0] product
);

    localparam int SW = XLEN / MUL_CYCLES;
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic            busy;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] a_sh;
    logic [XLEN-1:0] b_sh;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] partial;

    always_comb begin
        partial = '0;
        for (int j = 0; j < SW; j++) begin
            if (b_sh[j]) begin
                partial = partial + (a_sh << j);
            end
        end
    end

    assign last    = busy && (cnt == CW'(MUL_CYCLES - 1));
    // Final slice is folded in combinationally so the product is ready on last.
    assign product = acc + partial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
        end else if (!hold) begin
            if (start) begin
                busy <= 1'b1;
                cnt  <= '0;
                a_sh <= a;
                b_sh <= b;
                acc  <= '0;
            end else if (busy) begin
                acc  <= product;
                a_sh <= a_sh << SW;
                b_sh <= b_sh >> SW;
                if (last) begin
                    busy <= 1'b0;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ixu_ex_stage.sv
// IXU execute stage: forwarding, single-cycle ALU, iterative MUL, EX/WB register.
module ixu_ex_stage
    import ixu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic [3:0]      op_in,
    input  logic            is_nop_in,
    input  logic            is_imm_type_in,
    input  logic [4:0]      rs1_in,
    input  logic [4:0]      rs2_in,
    input  logic [4:0]      rd_in,
    input  logic [11:0]     imm_in,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic            stall_out,
    output logic            illegal_op,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_result,
    output logic            wb_is_nop
);

    ixu_ex_state_e   state;
    ixu_op_e         op;
    logic            valid;
    logic            legal;
    logic            is_mul;
    logic            mul_start;
    logic            mul_last;
    logic [4:0]      mul_rd;
    logic [4:0]      shamt;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mul_prod;

    assign rf_raddr1 = rs1_in;
    assign rf_raddr2 = rs2_in;

    assign op        = ixu_op_e'(op_in);
    assign valid     = !is_nop_in && !stall_in;
    assign legal     = (op_in <= 4'd10);
    assign is_mul    = (op == OP_MUL);
    assign mul_start = (state == IDLE) && valid && is_mul;

    // Only the immediately preceding result is bypassed; older ones come from the rf.
    always_comb begin
        fwd1 = rf_rdata1;
        if (rs1_in == 5'd0) begin
            fwd1 = '0;
        end else if (wb_we && wb_rd == rs1_in) begin
            fwd1 = wb_result;
        end
    end

    always_comb begin
        fwd2 = rf_rdata2;
        if (rs2_in == 5'd0) begin
            fwd2 = '0;
        end else if (wb_we && wb_rd == rs2_in) begin
            fwd2 = wb_result;
        end
    end

    assign imm_ext = XLEN'(sext12(imm_in));
    assign op_a    = fwd1;
    assign op_b    = is_imm_type_in ? imm_ext : fwd2;
    assign shamt   = op_b[4:0];

    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default: alu_res = '0;
        endcase
    end

    ixu_mul_iter #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .hold    (stall_in),
        .a       (op_a),
        .b       (op_b),
        .last    (mul_last),
        .product (mul_prod)
    );

    // Gated by rst so the hold request falls the moment reset hits.
    assign stall_out = !rst &&
        (stall_in || mul_start || (state == MUL_BUSY && !mul_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mul_rd     <= '0;
            illegal_op <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_result  <= '0;
            wb_is_nop  <= 1'b1;
        end else if (stall_in) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= '0;
            wb_result  <= '0;
            wb_is_nop  <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        if (!legal) begin
                            illegal_op <= 1'b1;
                        end else if (is_mul) begin
                            state  <= MUL_BUSY;
                            mul_rd <= rd_in;
                        end else begin
                            wb_we     <= (rd_in != 5'd0);
                            wb_rd     <= rd_in;
                            wb_result <= alu_res;
                            wb_is_nop <= 1'b0;
                        end
                    end
                end
                MUL_BUSY: begin
                    if (mul_last) begin
                        state     <= IDLE;
                        wb_we     <= (mul_rd != 5'd0);
                        wb_rd     <= mul_rd;
                        wb_result <= mul_prod;
                        wb_is_nop <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ixu_ex_stage.sv
// Directed bench for ixu_ex_stage with an abstract per-cycle reference model.
module tb_ixu_ex_stage;

    localparam int NCYC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic [3:0]  op_in = '0;
    logic        is_nop_in = 1'b1;
    logic        is_imm_type_in = 1'b0;
    logic [4:0]  rs1_in = '0;
    logic [4:0]  rs2_in = '0;
    logic [4:0]  rd_in = '0;
    logic [11:0] imm_in = '0;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        stall_out;
    logic        illegal_op;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        wb_is_nop;

    logic [31:0] rf [32];
    int tests = 0;
    int fails = 0;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk = ~clk;

    ixu_ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .op_in          (op_in),
        .is_nop_in      (is_nop_in),
        .is_imm_type_in (is_imm_type_in),
        .rs1_in         (rs1_in),
        .rs2_in         (rs2_in),
        .rd_in          (rd_in),
        .imm_in         (imm_in),
        .rf_raddr1      (rf_raddr1),
        .rf_raddr2      (rf_raddr2),
        .rf_rdata1      (rf_rdata1),
        .rf_rdata2      (rf_rdata2),
        .stall_out      (stall_out),
        .illegal_op     (illegal_op),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_result      (wb_result),
        .wb_is_nop      (wb_is_nop)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: EX/WB contents plus a countdown for the multiply.
    logic        m_we = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_res = '0;
    logic        m_nop = 1'b1;
    logic        m_ill = 1'b0;
    logic        m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_prod = '0;
    logic [4:0]  m_mrd = '0;

    function automatic logic [31:0] mfwd(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (m_we && m_rd == r) return m_res;
        return rf[r];
    endfunction

    function automatic logic [31:0] malu(input int op, input logic [31:0] a,
                                         input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return a << sh;
            6: return a >> sh;
            7: return 32'($signed(a) >>> sh);
            8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            9: return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic mstall();
        if (rst) return 1'b0;
        if (stall_in) return 1'b1;
        if (m_busy) return m_left > 1;
        return !is_nop_in && op_in == 4'd10;
    endfunction

    task automatic mbubble();
        m_we = 1'b0;
        m_rd = '0;
        m_res = '0;
        m_nop = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mbubble();
                m_ill = 1'b0;
                m_busy = 1'b0;
                m_left = 0;
            end else if (stall_in) begin
                m_ill = 1'b0;
            end else if (m_busy) begin
                m_ill = 1'b0;
                if (m_left > 1) begin
                    mbubble();
                    m_left--;
                end else begin
                    m_we = (m_mrd != 5'd0);
                    m_rd = m_mrd;
                    m_res = m_prod;
                    m_nop = 1'b0;
                    m_busy = 1'b0;
                end
            end else begin
                m_ill = 1'b0;
                a = mfwd(rs1_in);
                b = is_imm_type_in ? {{20{imm_in[11]}}, imm_in} : mfwd(rs2_in);
                if (is_nop_in) begin
                    mbubble();
                end else if (op_in > 4'd10) begin
                    mbubble();
                    m_ill = 1'b1;
                end else if (op_in == 4'd10) begin
                    m_busy = 1'b1;
                    m_left = NCYC;
                    m_prod = a * b;
                    m_mrd = rd_in;
                    mbubble();
                end else begin
                    m_res = malu(int'(op_in), a, b);
                    m_we = (rd_in != 5'd0);
                    m_rd = rd_in;
                    m_nop = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cyc_wb_we", 32'(wb_we), 32'(m_we));
            check("cyc_wb_rd", 32'(wb_rd), 32'(m_rd));
            check("cyc_wb_result", wb_result, m_res);
            check("cyc_wb_is_nop", 32'(wb_is_nop), 32'(m_nop));
            check("cyc_illegal_op", 32'(illegal_op), 32'(m_ill));
            check("cyc_stall_out", 32'(stall_out), 32'(mstall()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int op, input int r1, input int r2, input int rd,
                         input logic [11:0] imm, input logic isimm);
        op_in = op[3:0];
        rs1_in = r1[4:0];
        rs2_in = r2[4:0];
        rd_in = rd[4:0];
        imm_in = imm;
        is_imm_type_in = isimm;
        is_nop_in = 1'b0;
    endtask

    // Present an instruction and hold it until stall_out falls, like ID/EX does.
    task automatic run(input int op, input int r1, input int r2, input int rd,
                       input logic [11:0] imm, input logic isimm,
                       output int stalls);
        bit done;
        drive(op, r1, r2, rd, imm, isimm);
        stalls = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (!stall_out) begin
                done = 1;
            end else begin
                stalls++;
                if (stalls > 40) begin
                    tests++;
                    fails++;
                    $display("FAIL stall_timeout: got %0d stall cycles, expected <= 40", stalls);
                    done = 1;
                end
                @(posedge clk);
            end
        end
        tick();
        is_nop_in = 1'b1;
    endtask

    logic [31:0] sweep_exp [2:9];

    initial begin
        int st;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rf[0] = 32'h0000_1234;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rf[5] = 32'd7;
        rf[6] = 32'hFFFF_FFFD;
        sweep_exp[2] = 32'h0000_0005;
        sweep_exp[3] = 32'hFFFF_FFFD;
        sweep_exp[4] = 32'hFFFF_FFF8;
        sweep_exp[5] = 32'hFFFF_FFA0;
        sweep_exp[6] = 32'h07FF_FFFF;
        sweep_exp[7] = 32'hFFFF_FFFF;
        sweep_exp[8] = 32'h0000_0001;
        sweep_exp[9] = 32'h0000_0000;

        repeat (2) @(posedge clk);
        #2;
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_is_nop", 32'(wb_is_nop), 32'd1);
        check("rst_wb_result", wb_result, 32'd0);
        check("rst_stall_out", 32'(stall_out), 32'd0);
        check("rst_illegal_op", 32'(illegal_op), 32'd0);
        rst = 1'b0;
        tick();

        run(0, 1, 0, 7, 12'hFFD, 1'b1, st);
        check("addi_we", 32'(wb_we), 32'd1);
        check("addi_result", wb_result, 32'd2);

        run(0, 1, 2, 3, 12'h000, 1'b0, st);
        check("add_result", wb_result, 32'd12);
        run(1, 3, 1, 4, 12'h000, 1'b0, st);
        check("fwd_sub_result", wb_result, 32'd7);

        run(10, 5, 6, 8, 12'h000, 1'b0, st);
        check("mul_stall_cycles", 32'(st), 32'd4);
        check("mul_result", wb_result, 32'hFFFF_FFEB);
        check("mul_rd", 32'(wb_rd), 32'd8);
        run(0, 8, 0, 9, 12'h000, 1'b0, st);
        check("fwd_mul_x0_result", wb_result, 32'hFFFF_FFEB);

        run(10, 1, 0, 13, 12'h800, 1'b1, st);
        check("muli_result", wb_result, 32'hFFFF_D800);

        run(0, 1, 2, 0, 12'h000, 1'b0, st);
        check("x0_write_we", 32'(wb_we), 32'd0);
        run(13, 1, 2, 4, 12'h000, 1'b0, st);
        check("rsv_illegal_op", 32'(illegal_op), 32'd1);
        check("rsv_we", 32'(wb_we), 32'd0);
        check("rsv_is_nop", 32'(wb_is_nop), 32'd1);
        run(0, 0, 1, 10, 12'h000, 1'b0, st);
        check("after_rsv_illegal_op", 32'(illegal_op), 32'd0);
        check("x0_read_result", wb_result, 32'd5);

        for (int op = 2; op <= 9; op++) begin
            run(op, 6, 1, 20 + op, 12'h000, 1'b0, st);
            check("sweep_result", wb_result, sweep_exp[op]);
        end

        drive(10, 5, 6, 14, 12'h000, 1'b0);
        tick();
        tick();
        tick();
        #1;
        rst = 1'b1;
        is_nop_in = 1'b1;
        #1;
        check("rst_mid_stall_out", 32'(stall_out), 32'd0);
        check("rst_mid_is_nop", 32'(wb_is_nop), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        run(0, 1, 2, 11, 12'h000, 1'b0, st);
        check("post_rst_add_we", 32'(wb_we), 32'd1);
        check("post_rst_add_result", wb_result, 32'd12);

        drive(10, 5, 6, 15, 12'h000, 1'b0);
        tick();
        tick();
        stall_in = 1'b1;
        repeat (3) tick();
        check("stall_hold_is_nop", 32'(wb_is_nop), 32'd1);
        stall_in = 1'b0;
        run(10, 5, 6, 15, 12'h000, 1'b0, st);
        check("stall_mul_tail", 32'(st), 32'd2);
        check("stall_mul_result", wb_result, 32'hFFFF_FFEB);
        check("stall_mul_rd", 32'(wb_rd), 32'd15);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
